// File: rtl/i2s_sample_sched.sv
// Stereo sample scheduler: buffers producer pairs in a FIFO and releases one pair per frame period.
// Optional macro I2S_SCHED_UNDERRUN_MUTE_EN: underrun strobes output zeros instead of repeating the last pair.
module i2s_sample_sched #(
    parameter int DATA_BITS  = 24,
    parameter int FIFO_DEPTH = 8,
    parameter int FRAME_DIV  = 256
) (
    input  logic                                AMCLK_i,
    input  logic                                reset,
    input  logic                                enable_i,
    input  logic                                downsample_2x,
    input  logic signed [DATA_BITS-1:0]         src_left_i,
    input  logic signed [DATA_BITS-1:0]         src_right_i,
    input  logic                                src_valid_i,
    output logic                                src_ready_o,
    output logic signed [DATA_BITS-1:0]         out_left_o,
    output logic signed [DATA_BITS-1:0]         out_right_o,
    output logic                                out_valid_o,
    output logic [$clog2(FIFO_DEPTH):0]         fill_o,
    output logic                                underrun_o,
    output logic                                overflow_o,
    input  logic                                clear_flags_i
);
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = $clog2(FRAME_DIV) + 1;
`ifdef I2S_SCHED_UNDERRUN_MUTE_EN
    localparam bit MUTE_ON = 1'b1;
`else
    localparam bit MUTE_ON = 1'b0;
`endif

    typedef enum logic [1:0] {IDLE, PRIME, RUN} state_t;

    state_t                      state_q, state_d;
    logic [PTR_W-1:0]            wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [PTR_W:0]              fill_q, fill_d;
    logic [CNT_W-1:0]            cnt_q, cnt_d;
    logic                        p2x_q, p2x_d;
    logic                        out_valid_q, out_valid_d;
    logic signed [DATA_BITS-1:0] out_l_q, out_l_d, out_r_q, out_r_d;
    logic                        underrun_q, underrun_d, overflow_q, overflow_d;
    logic signed [DATA_BITS-1:0] mem_l_q [FIFO_DEPTH];
    logic signed [DATA_BITS-1:0] mem_r_q [FIFO_DEPTH];
    logic                        full, empty, frame_end, pop, push, ovf_evt, unr_evt;

    function automatic logic [CNT_W-1:0] last_count(input logic dbl);
        return dbl ? CNT_W'(2 * FRAME_DIV - 1) : CNT_W'(FRAME_DIV - 1);
    endfunction

    always_comb begin
        full      = (fill_q == (PTR_W+1)'(FIFO_DEPTH));
        empty     = (fill_q == '0);
        frame_end = (state_q == RUN) && enable_i && (cnt_q == last_count(p2x_q));
        pop       = frame_end && !empty;
        unr_evt   = frame_end && empty;
        // A pop on the same edge frees the slot, so a full FIFO still accepts the push.
        push      = enable_i && (state_q != IDLE) && src_valid_i && (!full || pop);
        ovf_evt   = enable_i && (state_q != IDLE) && src_valid_i && full && !pop;

        state_d     = state_q;
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        cnt_d       = cnt_q;
        p2x_d       = p2x_q;
        out_valid_d = frame_end;
        out_l_d     = out_l_q;
        out_r_d     = out_r_q;

        case (state_q)
            IDLE: begin
                if (enable_i) state_d = PRIME;
            end
            PRIME: begin
                if (fill_q >= (PTR_W+1)'(FIFO_DEPTH / 2)) begin
                    state_d = RUN;
                    cnt_d   = '0;
                    p2x_d   = downsample_2x;
                end
            end
            RUN: begin
                // The period length is latched only at a wrap so a frame never changes length mid-way.
                if (frame_end) begin
                    cnt_d = '0;
                    p2x_d = downsample_2x;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase

        if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
            out_l_d  = mem_l_q[rd_ptr_q];
            out_r_d  = mem_r_q[rd_ptr_q];
        end
        if (unr_evt && MUTE_ON) begin
            out_l_d = '0;
            out_r_d = '0;
        end
        fill_d = fill_q + (PTR_W+1)'(push) - (PTR_W+1)'(pop);

        underrun_d = unr_evt || (underrun_q && !clear_flags_i);
        overflow_d = ovf_evt || (overflow_q && !clear_flags_i);

        if (!enable_i) begin
            state_d  = IDLE;
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            fill_d   = '0;
            cnt_d    = '0;
        end
    end

    always_ff @(posedge AMCLK_i) begin
        if (reset) begin
            state_q     <= IDLE;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            fill_q      <= '0;
            cnt_q       <= '0;
            p2x_q       <= 1'b0;
            out_valid_q <= 1'b0;
            out_l_q     <= '0;
            out_r_q     <= '0;
            underrun_q  <= 1'b0;
            overflow_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            fill_q      <= fill_d;
            cnt_q       <= cnt_d;
            p2x_q       <= p2x_d;
            out_valid_q <= out_valid_d;
            out_l_q     <= out_l_d;
            out_r_q     <= out_r_d;
            underrun_q  <= underrun_d;
            overflow_q  <= overflow_d;
        end
    end

    always_ff @(posedge AMCLK_i) begin
        if (push && !reset) begin
            mem_l_q[wr_ptr_q] <= src_left_i;
            mem_r_q[wr_ptr_q] <= src_right_i;
        end
    end

    assign src_ready_o = (state_q != IDLE) && !full;
    assign out_left_o  = out_l_q;
    assign out_right_o = out_r_q;
    assign out_valid_o = out_valid_q;
    assign fill_o      = fill_q;
    assign underrun_o  = underrun_q;
    assign overflow_o  = overflow_q;
endmodule

// File: tb/tb_i2s_sample_sched.sv
// Randomised bench for i2s_sample_sched against a queue-based frame-deadline reference model.
module tb_i2s_sample_sched;
    localparam int DW    = 24;
    localparam int DEPTH = 8;
    localparam int FRAME = 256;
`ifdef I2S_SCHED_UNDERRUN_MUTE_EN
    localparam bit MUTE = 1'b1;
`else
    localparam bit MUTE = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1, en = 1'b0, ds = 1'b0, src_vld = 1'b0, clr = 1'b0;
    logic signed [DW-1:0] src_l = '0, src_r = '0;
    logic signed [DW-1:0] out_l, out_r;
    logic src_rdy, out_vld, unr, ovf;
    logic [$clog2(DEPTH):0] fill;

    i2s_sample_sched #(.DATA_BITS(DW), .FIFO_DEPTH(DEPTH), .FRAME_DIV(FRAME)) dut (
        .AMCLK_i(clk), .reset(rst), .enable_i(en), .downsample_2x(ds),
        .src_left_i(src_l), .src_right_i(src_r), .src_valid_i(src_vld),
        .src_ready_o(src_rdy), .out_left_o(out_l), .out_right_o(out_r),
        .out_valid_o(out_vld), .fill_o(fill), .underrun_o(unr),
        .overflow_o(ovf), .clear_flags_i(clr)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    task automatic chk(input string tag, input logic signed [63:0] got, input logic signed [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    // Reference model: mode 0=idle 1=prime 2=run; strobes scheduled by absolute edge number.
    int cyc = 0;
    int m_mode = 0;
    int m_next = 0;
    bit m_vld = 0, m_unr = 0, m_ovf = 0;
    logic signed [DW-1:0] m_l = '0, m_r = '0;
    logic signed [DW-1:0] ql[$];
    logic signed [DW-1:0] qr[$];
    bit mdl_on = 0;

    always @(posedge clk) begin
        int  sz;
        bit  strobe, popped, uevt, oevt;
        cyc++;
        if (rst) begin
            m_mode = 0; m_vld = 0; m_unr = 0; m_ovf = 0; m_l = '0; m_r = '0;
            ql.delete(); qr.delete();
        end else if (!en) begin
            m_mode = 0; m_vld = 0;
            ql.delete(); qr.delete();
            m_unr = m_unr && !clr;
            m_ovf = m_ovf && !clr;
        end else begin
            sz = ql.size();
            strobe = (m_mode == 2) && (cyc == m_next);
            popped = 0; uevt = 0; oevt = 0;
            m_vld = strobe;
            if (strobe) begin
                if (sz > 0) begin
                    m_l = ql.pop_front(); m_r = qr.pop_front(); popped = 1;
                end else begin
                    uevt = 1;
                    if (MUTE) begin m_l = '0; m_r = '0; end
                end
                m_next = cyc + (ds ? 2 * FRAME : FRAME);
            end
            if (m_mode != 0 && src_vld) begin
                if (sz < DEPTH || popped) begin
                    ql.push_back(src_l); qr.push_back(src_r);
                end else oevt = 1;
            end
            if (m_mode == 0) m_mode = 1;
            else if (m_mode == 1 && sz >= DEPTH / 2) begin
                m_mode = 2;
                m_next = cyc + (ds ? 2 * FRAME : FRAME);
            end
            m_unr = uevt || (m_unr && !clr);
            m_ovf = oevt || (m_ovf && !clr);
        end
    end

    always @(negedge clk) begin
        if (mdl_on) begin
            chk("vld", out_vld, m_vld);
            chk("left", out_l, m_l);
            chk("right", out_r, m_r);
            chk("fill", fill, ql.size());
            chk("ready", src_rdy, (m_mode != 0) && (ql.size() < DEPTH));
            chk("underrun", unr, m_unr);
            chk("overflow", ovf, m_ovf);
        end
    end

    task automatic wait_strobe(input int limit, output int at);
        at = -1;
        for (int i = 0; i < limit; i++) begin
            @(negedge clk);
            if (out_vld) begin
                at = cyc;
                break;
            end
        end
        if (at < 0) chk("strobe_timeout", 0, 1);
    endtask

    initial begin
        int c0, t1, t2, t3, t4, t5, t6, thr, nstrb;
        repeat (3) @(negedge clk);
        mdl_on = 1;
        chk("rst_fill", fill, 0);
        chk("rst_vld", out_vld, 0);
        chk("rst_ready", src_rdy, 0);
        chk("rst_left", out_l, 0);
        chk("rst_flags", {unr, ovf}, 0);

        rst = 0; en = 1;
        @(negedge clk);
        chk("prime_ready", src_rdy, 1);
        for (int n = 1; n <= 4; n++) begin
            src_vld = 1; src_l = DW'(n); src_r = -DW'(n);
            @(negedge clk);
        end
        src_vld = 0;
        c0 = cyc;
        chk("prime_fill", fill, 4);

        wait_strobe(600, t1);
        chk("first_dly", t1 - c0, FRAME + 1);
        chk("first_l", out_l, 1);
        chk("first_r", out_r, -1);
        wait_strobe(600, t2);
        chk("period", t2 - t1, FRAME);
        chk("second_l", out_l, 2);

        repeat (100) @(negedge clk);
        ds = 1;
        wait_strobe(600, t3);
        chk("ds_cur_period", t3 - t2, FRAME);
        ds = 0;
        wait_strobe(800, t4);
        chk("ds_long_period", t4 - t3, 2 * FRAME);
        chk("fourth_l", out_l, 4);

        wait_strobe(600, t5);
        chk("back_period", t5 - t4, FRAME);
        chk("underrun_set", unr, 1);
        chk("underrun_l", out_l, MUTE ? 0 : 4);
        chk("underrun_r", out_r, MUTE ? 0 : -4);
        clr = 1;
        @(negedge clk);
        clr = 0;
        chk("underrun_clr", unr, 0);

        for (int i = 0; i < DEPTH; i++) begin
            src_vld = 1; src_l = DW'(100 + i); src_r = DW'(-100 - i);
            @(negedge clk);
        end
        src_l = DW'(200); src_r = DW'(-200);
        @(negedge clk);
        chk("ovf_flag", ovf, 1);
        chk("ovf_ready", src_rdy, 0);
        chk("ovf_fill", fill, DEPTH);
        src_l = DW'(300); src_r = DW'(-300);
        wait_strobe(600, t6);
        src_vld = 0;
        chk("full_pop_period", t6 - t5, FRAME);
        chk("full_pop_fill", fill, DEPTH);
        chk("full_pop_l", out_l, 100);
        clr = 1;
        @(negedge clk);
        clr = 0;

        thr = 16;
        for (int i = 0; i < 30000; i++) begin
            if (i % 2500 == 0) thr = 8 * $urandom_range(1, 3);
            src_vld = ($urandom_range(0, 4095) < thr);
            src_l = DW'($urandom);
            src_r = DW'($urandom);
            if ($urandom_range(0, 999) == 0) ds = ~ds;
            clr = ($urandom_range(0, 499) == 0);
            en  = ($urandom_range(0, 4999) != 0);
            rst = ($urandom_range(0, 7999) == 0);
            @(negedge clk);
        end
        src_vld = 0; clr = 0; rst = 0; en = 1;
        repeat (50) @(negedge clk);

        en = 0;
        @(negedge clk);
        chk("dis_fill", fill, 0);
        chk("dis_ready", src_rdy, 0);
        rst = 1; en = 1;
        repeat (5) @(negedge clk);
        rst = 0;
        nstrb = 0;
        for (int i = 0; i < 600; i++) begin
            @(negedge clk);
            if (out_vld) nstrb++;
        end
        chk("post_rst_strobes", nstrb, 0);
        chk("post_rst_fill", fill, 0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule
